// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types, control constants and limits for pipe_ctrl.
// Forwarding is enabled by defining PIPE_CTRL_FORWARDING_EN.
package pipe_pkg;

  localparam int MIN_STAGES = 5;
  localparam int MAX_STAGES = 8;
  localparam int MAX_REG_AW = 8;

  localparam int FW_SEL_RF = 0;

  typedef logic [MAX_REG_AW-1:0] regAddr_t;

  typedef struct packed {
    logic     valid;
    regAddr_t dest;
    logic     wbEn;
    logic     memREn;
  } shadowEntry_t;

  typedef struct packed {
    regAddr_t src1;
    regAddr_t src2;
  } exeSrc_t;

  typedef struct packed {
    logic pcEn;
    logic ifIdEn;
    logic ifIdFlush;
    logic idExBubble;
    logic pipeEn;
  } pipeCtrl_t;

  localparam shadowEntry_t NOP_ENTRY = '0;
  localparam exeSrc_t      NOP_SRC   = '0;

  localparam pipeCtrl_t CTRL_RESET = '{
    pcEn:       1'b0,
    ifIdEn:     1'b0,
    ifIdFlush:  1'b1,
    idExBubble: 1'b1,
    pipeEn:     1'b1
  };

  localparam pipeCtrl_t CTRL_FREEZE = '{
    pcEn:       1'b0,
    ifIdEn:     1'b0,
    ifIdFlush:  1'b0,
    idExBubble: 1'b0,
    pipeEn:     1'b0
  };

  localparam pipeCtrl_t CTRL_BRANCH = '{
    pcEn:       1'b1,
    ifIdEn:     1'b1,
    ifIdFlush:  1'b1,
    idExBubble: 1'b1,
    pipeEn:     1'b1
  };

  localparam pipeCtrl_t CTRL_STALL = '{
    pcEn:       1'b0,
    ifIdEn:     1'b0,
    ifIdFlush:  1'b0,
    idExBubble: 1'b1,
    pipeEn:     1'b1
  };

  localparam pipeCtrl_t CTRL_RUN = '{
    pcEn:       1'b1,
    ifIdEn:     1'b1,
    ifIdFlush:  1'b0,
    idExBubble: 1'b0,
    pipeEn:     1'b1
  };

  function automatic bit paramsOk(
    input int numStages,
    input int regAw
  );
    return (numStages >= MIN_STAGES) &&
           (numStages <= MAX_STAGES) &&
           (regAw >= 1) &&
           (regAw <= MAX_REG_AW);
  endfunction

endpackage

// File: rtl/pipe_ctrl_shadow.sv
// pipe_ctrl_shadow: in-flight instruction scoreboard, EXE..WB.
// Holds when en is low; inserts a NOP entry when bubble is set.
module pipe_ctrl_shadow
  import pipe_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         bubble,
  input  shadowEntry_t newEntry,
  input  exeSrc_t      newSrc,
  output shadowEntry_t entries [DEPTH],
  output exeSrc_t      exeSrc
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        entries[k] <= NOP_ENTRY;
      end
      exeSrc <= NOP_SRC;
    end else if (en) begin
      entries[0] <= bubble ? NOP_ENTRY : newEntry;
      exeSrc     <= bubble ? NOP_SRC : newSrc;
      for (int k = 1; k < DEPTH; k++) begin
        entries[k] <= entries[k-1];
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard, stall/flush and forwarding control for NUM_STAGES.
// Define PIPE_CTRL_FORWARDING_EN to enable EXE operand forwarding.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter  int NUM_STAGES = 5,
  parameter  int REG_AW     = 5,
  localparam int FW_W       = $clog2(NUM_STAGES-2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_src1_used,
  input  logic              id_src2_used,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic              br_taken,
  input  logic              mem_busy,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              pipe_en,
  output logic              hazard,
  output logic [FW_W-1:0]   fwd_src1_sel,
  output logic [FW_W-1:0]   fwd_src2_sel
);

  localparam int D = NUM_STAGES - 2;

  if (!paramsOk(NUM_STAGES, REG_AW)) begin : gBadParams
    $error("pipe_ctrl: unsupported NUM_STAGES or REG_AW");
  end

  shadowEntry_t entries [D];
  exeSrc_t      exeSrc;
  shadowEntry_t newEntry;
  exeSrc_t      newSrc;
  regAddr_t     src1Ext;
  regAddr_t     src2Ext;
  logic         insBubble;
  logic         rawHazard;
  logic         selRst;
  logic         selFreeze;
  logic         selBranch;
  logic         selStall;
  pipeCtrl_t    ctrl;

  assign src1Ext = regAddr_t'(id_src1);
  assign src2Ext = regAddr_t'(id_src2);

  assign newEntry = '{
    valid:  1'b1,
    dest:   regAddr_t'(id_dest),
    wbEn:   id_wb_en,
    memREn: id_mem_r_en
  };

  assign newSrc = '{
    src1: src1Ext,
    src2: src2Ext
  };

  assign insBubble = ctrl.idExBubble | ~id_valid;

  pipe_ctrl_shadow #(
    .DEPTH (D)
  ) uShadow (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl.pipeEn),
    .bubble   (insBubble),
    .newEntry (newEntry),
    .newSrc   (newSrc),
    .entries  (entries),
    .exeSrc   (exeSrc)
  );

  function automatic logic srcMatch(
    input shadowEntry_t e,
    input regAddr_t     s,
    input logic         used
  );
    return e.valid & e.wbEn & (e.dest == s) &
           (s != '0) & used;
  endfunction

  always_comb begin
    rawHazard = 1'b0;
`ifdef PIPE_CTRL_FORWARDING_EN
    rawHazard = entries[0].memREn &
      (srcMatch(entries[0], src1Ext, id_src1_used) |
       srcMatch(entries[0], src2Ext, id_src2_used));
`else
    // WB is excluded: the register file writes before it is read.
    for (int k = 0; k < D-1; k++) begin
      rawHazard = rawHazard |
        srcMatch(entries[k], src1Ext, id_src1_used) |
        srcMatch(entries[k], src2Ext, id_src2_used);
    end
`endif
  end

  assign selRst    = ~rst;
  assign selFreeze = rst & mem_busy;
  assign selBranch = rst & ~mem_busy & br_taken;
  assign selStall  = rst & ~mem_busy & ~br_taken & rawHazard;

  always_comb begin
    ctrl = CTRL_RUN;
    unique case (1'b1)
      selRst:    ctrl = CTRL_RESET;
      selFreeze: ctrl = CTRL_FREEZE;
      selBranch: ctrl = CTRL_BRANCH;
      selStall:  ctrl = CTRL_STALL;
      default:   ctrl = CTRL_RUN;
    endcase
  end

  assign pc_en        = ctrl.pcEn;
  assign if_id_en     = ctrl.ifIdEn;
  assign if_id_flush  = ctrl.ifIdFlush;
  assign id_ex_bubble = ctrl.idExBubble;
  assign pipe_en      = ctrl.pipeEn;
  assign hazard       = selStall;

`ifdef PIPE_CTRL_FORWARDING_EN
  logic [FW_W-1:0] sel1;
  logic [FW_W-1:0] sel2;

  // Scan oldest to youngest so the youngest producer wins.
  always_comb begin
    sel1 = FW_W'(FW_SEL_RF);
    sel2 = FW_W'(FW_SEL_RF);
    for (int j = D-1; j >= 1; j--) begin
      if (srcMatch(entries[j], exeSrc.src1, 1'b1)) begin
        sel1 = FW_W'(j);
      end
      if (srcMatch(entries[j], exeSrc.src2, 1'b1)) begin
        sel2 = FW_W'(j);
      end
    end
  end

  assign fwd_src1_sel = rst ? sel1 : FW_W'(FW_SEL_RF);
  assign fwd_src2_sel = rst ? sel2 : FW_W'(FW_SEL_RF);
`else
  assign fwd_src1_sel = FW_W'(FW_SEL_RF);
  assign fwd_src2_sel = FW_W'(FW_SEL_RF);
`endif

  logic unusedSink;

  always_comb begin
    unusedSink = 1'b0;
    for (int k = 1; k < D; k++) begin
      unusedSink = unusedSink ^ entries[k].memREn;
    end
`ifndef PIPE_CTRL_FORWARDING_EN
    unusedSink = unusedSink ^ entries[0].memREn ^
                 (^exeSrc) ^ (^entries[D-1]);
`endif
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of stall, flush, freeze and forwarding.
// Expectations follow PIPE_CTRL_FORWARDING_EN when it is defined.
module tb_pipe_ctrl;

  localparam logic [5:0] RUN    = 6'b110010;
  localparam logic [5:0] STALL  = 6'b000111;
  localparam logic [5:0] BRANCH = 6'b111110;
  localparam logic [5:0] FREEZE = 6'b000000;
  localparam logic [5:0] RESET  = 6'b001110;

`ifdef PIPE_CTRL_FORWARDING_EN
  localparam int NS       = 5;
  localparam int ALU_HZ   = 0;
  localparam int LOAD_HZ  = 1;
  localparam int ALU_SEL1 = 1;
  localparam int ALU_SEL2 = 2;
  localparam int LOAD_SEL = 2;
  localparam logic [5:0] READER_CTL = RUN;
`else
  localparam int NS       = 6;
  localparam int ALU_HZ   = 3;
  localparam int LOAD_HZ  = 3;
  localparam int ALU_SEL1 = 0;
  localparam int ALU_SEL2 = 0;
  localparam int LOAD_SEL = 0;
  localparam logic [5:0] READER_CTL = STALL;
`endif

  localparam int AW = 5;
  localparam int FW = $clog2(NS-2);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_src1 = '0;
  logic [AW-1:0] id_src2 = '0;
  logic          id_src1_used = 1'b0;
  logic          id_src2_used = 1'b0;
  logic [AW-1:0] id_dest = '0;
  logic          id_wb_en = 1'b0;
  logic          id_mem_r_en = 1'b0;
  logic          br_taken = 1'b0;
  logic          mem_busy = 1'b0;
  logic          pc_en;
  logic          if_id_en;
  logic          if_id_flush;
  logic          id_ex_bubble;
  logic          pipe_en;
  logic          hazard;
  logic [FW-1:0] fwd_src1_sel;
  logic [FW-1:0] fwd_src2_sel;

  int total = 0;
  int bad = 0;

  wire [5:0] ctl = {pc_en, if_id_en, if_id_flush,
                    id_ex_bubble, pipe_en, hazard};

  always #5 clk = ~clk;

  pipe_ctrl #(
    .NUM_STAGES (NS),
    .REG_AW     (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .id_dest      (id_dest),
    .id_wb_en     (id_wb_en),
    .id_mem_r_en  (id_mem_r_en),
    .br_taken     (br_taken),
    .mem_busy     (mem_busy),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .pipe_en      (pipe_en),
    .hazard       (hazard),
    .fwd_src1_sel (fwd_src1_sel),
    .fwd_src2_sel (fwd_src2_sel)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setId(
    input logic          v,
    input logic [AW-1:0] s1,
    input logic          u1,
    input logic [AW-1:0] s2,
    input logic          u2,
    input logic [AW-1:0] d,
    input logic          wb,
    input logic          mr
  );
    id_valid     = v;
    id_src1      = s1;
    id_src1_used = u1;
    id_src2      = s2;
    id_src2_used = u2;
    id_dest      = d;
    id_wb_en     = wb;
    id_mem_r_en  = mr;
  endtask

  task automatic idle(input int n);
    setId(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    br_taken = 1'b0;
    mem_busy = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    setId(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (ctl !== RESET) begin
        bad++;
        $display("FAIL reset_ctl c=%0d got=%b exp=%b", c, ctl, RESET);
      end
      total++;
      if ({fwd_src1_sel, fwd_src2_sel} !== '0) begin
        bad++;
        $display("FAIL reset_sel c=%0d got=%0d/%0d exp=0/0",
                 c, fwd_src1_sel, fwd_src2_sel);
      end
      tick();
    end
    rst = 1'b1;
    setId(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    total++;
    if (ctl !== RUN) begin
      bad++;
      $display("FAIL post_reset_ctl got=%b exp=%b", ctl, RUN);
    end
    total++;
    if ({fwd_src1_sel, fwd_src2_sel} !== '0) begin
      bad++;
      $display("FAIL post_reset_sel got=%0d/%0d exp=0/0",
               fwd_src1_sel, fwd_src2_sel);
    end
    idle(NS);
  endtask

  task automatic test_match_rules();
    setId(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    #1;
    total++;
    if (ctl !== RUN) begin
      bad++;
      $display("FAIL empty_run got=%b exp=%b", ctl, RUN);
    end
    tick();
    setId(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd8, 1'b1, 1'b0);
    #1;
    total++;
    if (ctl !== STALL) begin
      bad++;
      $display("FAIL src2_match got=%b exp=%b", ctl, STALL);
    end
    id_src2_used = 1'b0;
    #1;
    total++;
    if (ctl !== RUN) begin
      bad++;
      $display("FAIL src2_unused got=%b exp=%b", ctl, RUN);
    end
    id_src1 = 5'd9;
    id_src1_used = 1'b1;
    #1;
    total++;
    if (ctl !== STALL) begin
      bad++;
      $display("FAIL src1_match got=%b exp=%b", ctl, STALL);
    end
    idle(NS);

    setId(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b0, 1'b1);
    tick();
    setId(1'b1, 5'd10, 1'b1, 5'd10, 1'b1, 5'd8, 1'b1, 1'b0);
    #1;
    total++;
    if (ctl !== RUN) begin
      bad++;
      $display("FAIL no_wb_en got=%b exp=%b", ctl, RUN);
    end
    idle(NS);

    setId(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    setId(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
    #1;
    total++;
    if (ctl !== RUN) begin
      bad++;
      $display("FAIL r0_dest got=%b exp=%b", ctl, RUN);
    end
    idle(NS);

    setId(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1);
    tick();
    setId(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    #1;
    total++;
    if (ctl !== RUN) begin
      bad++;
      $display("FAIL invalid_prod got=%b exp=%b", ctl, RUN);
    end
    idle(NS);
  endtask

  task automatic test_alu_dep();
    setId(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    setId(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    for (int c = 0; c < ALU_HZ; c++) begin
      #1;
      total++;
      if (ctl !== STALL) begin
        bad++;
        $display("FAIL alu_stall c=%0d got=%b exp=%b", c, ctl, STALL);
      end
      tick();
    end
    #1;
    total++;
    if (ctl !== RUN) begin
      bad++;
      $display("FAIL alu_release got=%b exp=%b", ctl, RUN);
    end
    tick();
    setId(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    #1;
    total++;
    if (ctl !== RUN || fwd_src1_sel !== FW'(ALU_SEL1)) begin
      bad++;
      $display("FAIL alu_fwd1 got=%b/%0d exp=%b/%0d",
               ctl, fwd_src1_sel, RUN, ALU_SEL1);
    end
    tick();
    idle(0);
    #1;
    total++;
    if (fwd_src1_sel !== FW'(ALU_SEL2)) begin
      bad++;
      $display("FAIL alu_fwd2 got=%0d exp=%0d", fwd_src1_sel, ALU_SEL2);
    end
    idle(NS);
  endtask

  task automatic test_load_use();
    setId(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    setId(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    for (int c = 0; c < LOAD_HZ; c++) begin
      #1;
      total++;
      if (ctl !== STALL) begin
        bad++;
        $display("FAIL lu_stall c=%0d got=%b exp=%b", c, ctl, STALL);
      end
      tick();
    end
    #1;
    total++;
    if (ctl !== RUN) begin
      bad++;
      $display("FAIL lu_release got=%b exp=%b", ctl, RUN);
    end
    tick();
    idle(0);
    #1;
    total++;
    if (fwd_src1_sel !== FW'(LOAD_SEL) || fwd_src2_sel !== FW'(LOAD_SEL)) begin
      bad++;
      $display("FAIL lu_fwd got=%0d/%0d exp=%0d/%0d",
               fwd_src1_sel, fwd_src2_sel, LOAD_SEL, LOAD_SEL);
    end
    idle(NS);
  endtask

  task automatic test_branch();
    setId(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
    br_taken = 1'b1;
    #1;
    total++;
    if (ctl !== BRANCH) begin
      bad++;
      $display("FAIL br_plain got=%b exp=%b", ctl, BRANCH);
    end
    br_taken = 1'b0;
    tick();
    setId(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    br_taken = 1'b1;
    #1;
    total++;
    if (ctl !== BRANCH) begin
      bad++;
      $display("FAIL br_over_stall got=%b exp=%b", ctl, BRANCH);
    end
    br_taken = 1'b0;
    #1;
    total++;
    if (ctl !== STALL) begin
      bad++;
      $display("FAIL br_dropped got=%b exp=%b", ctl, STALL);
    end
    idle(NS);
  endtask

  task automatic test_mem_busy();
    setId(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    setId(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    mem_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      br_taken = (c == 1);
      #1;
      total++;
      if (ctl !== FREEZE || {fwd_src1_sel, fwd_src2_sel} !== '0) begin
        bad++;
        $display("FAIL freeze c=%0d got=%b/%0d exp=%b/0",
                 c, ctl, fwd_src1_sel, FREEZE);
      end
      tick();
    end
    br_taken = 1'b0;
    mem_busy = 1'b0;
    for (int c = 0; c < LOAD_HZ; c++) begin
      #1;
      total++;
      if (ctl !== STALL) begin
        bad++;
        $display("FAIL thaw_stall c=%0d got=%b exp=%b", c, ctl, STALL);
      end
      tick();
    end
    #1;
    total++;
    if (ctl !== RUN) begin
      bad++;
      $display("FAIL thaw_release got=%b exp=%b", ctl, RUN);
    end
    tick();
    setId(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    #1;
    total++;
    if (fwd_src1_sel !== FW'(LOAD_SEL)) begin
      bad++;
      $display("FAIL thaw_fwd got=%0d exp=%0d", fwd_src1_sel, LOAD_SEL);
    end
    total++;
    if (ctl !== READER_CTL) begin
      bad++;
      $display("FAIL thaw_reader got=%b exp=%b", ctl, READER_CTL);
    end
    idle(NS);
  endtask

`ifdef PIPE_CTRL_FORWARDING_EN
  task automatic test_back_to_back();
    setId(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    tick();
    setId(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    tick();
    setId(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0);
    #1;
    total++;
    if (ctl !== RUN) begin
      bad++;
      $display("FAIL b2b_run got=%b exp=%b", ctl, RUN);
    end
    tick();
    idle(0);
    #1;
    total++;
    if (fwd_src1_sel !== FW'(1) || fwd_src2_sel !== FW'(1)) begin
      bad++;
      $display("FAIL b2b_youngest got=%0d/%0d exp=1/1",
               fwd_src1_sel, fwd_src2_sel);
    end
    idle(NS);
    setId(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    setId(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    idle(0);
    #1;
    total++;
    if ({fwd_src1_sel, fwd_src2_sel} !== '0) begin
      bad++;
      $display("FAIL b2b_r0 got=%0d/%0d exp=0/0",
               fwd_src1_sel, fwd_src2_sel);
    end
    idle(NS);
  endtask
`endif

  initial begin
    test_reset();
    test_match_rules();
    test_alu_dep();
    test_load_use();
    test_branch();
    test_mem_busy();
`ifdef PIPE_CTRL_FORWARDING_EN
    test_back_to_back();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
